i2c_codec_target: RTL and testbench

Synthesizable I2C target (responder) that models the WM8731-style codec control port. It sits on the same two-wire bus driven by `i2c_config`. It decodes 7-bit-address write transactions of two data bytes (7-bit register address + 9-bit data), ACKs them, and stores the data in a register bank. Uses: loopback verification of `i2c_config` on-chip, and a codec stand-in for board bring-up without the codec fitted.

---
 rtl/codec_pkg.sv | 40 ++++
 rtl/i2c_bus_cond.sv | 67 ++++++
 rtl/i2c_codec_target.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2c_codec_target.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// codec_pkg
// Shared definitions for the WM8731-style codec control-port target:
// register-bank geometry, the bank-reset register address, the power-on
// register defaults and the protocol FSM state encoding.
package codec_pkg;

    localparam int         CODEC_NUM_REGS  = 10;
    localparam logic [6:0] CODEC_RESET_REG = 7'h0F;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_BYTE1    = 3'd3,
        ST_ACK1     = 3'd4,
        ST_BYTE2    = 3'd5,
        ST_ACK2     = 3'd6,
        ST_IGNORE   = 3'd7
    } codec_state_e;

    // Power-on value of register idx; indices outside the bank return zero.
    function automatic logic [8:0] codec_default(input logic [3:0] idx);
        logic [8:0] val;
        case (idx)
            4'd0:    val = 9'h097;
            4'd1:    val = 9'h097;
            4'd2:    val = 9'h079;
            4'd3:    val = 9'h079;
            4'd4:    val = 9'h00A;
            4'd5:    val = 9'h008;
            4'd6:    val = 9'h09F;
            4'd7:    val = 9'h00A;
            4'd8:    val = 9'h000;
            4'd9:    val = 9'h000;
            default: val = 9'h000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond
// Brings the asynchronous SCL/SDA pins into the clk domain and derives the
// bus events the protocol FSM needs.
//   clk, rst      system clock, synchronous active-high reset
//   scl_in/sda_in raw bus pins (asynchronous)
//   start         SDA fell while SCL stayed high
//   stop          SDA rose while SCL stayed high
//   scl_rise/fall single-cycle SCL edge strobes
//   sda_s         synchronized SDA level, used as the sampled data bit
// All event outputs appear SYNC_STAGES cycles after the pin edge; the FSM
// registers them once more.
module i2c_bus_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_d_r;
    logic                   sda_d_r;
    logic [SYNC_STAGES:0]   arm_r;
    logic                   scl_now_s;
    logic                   sda_now_s;
    logic                   armed_s;

    assign scl_now_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_now_s = sda_sync_r[SYNC_STAGES-1];
    assign armed_s   = arm_r[SYNC_STAGES];

    // Metastability chains; deliberately not reset so they always follow the pins.
    always_ff @(posedge clk) begin
        scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
        sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
    end

    // Previous synchronized levels; they track through reset so that a reset
    // in the middle of a transfer does not fabricate a START or STOP.
    always_ff @(posedge clk) begin
        scl_d_r <= scl_now_s;
        sda_d_r <= sda_now_s;
    end

    // Event mask after reset until the synchronizer chain has flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_r <= '0;
        end else begin
            arm_r <= {arm_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign start    = armed_s & scl_now_s & scl_d_r & sda_d_r & ~sda_now_s;
    assign stop     = armed_s & scl_now_s & scl_d_r & ~sda_d_r & sda_now_s;
    assign scl_rise = armed_s & scl_now_s & ~scl_d_r;
    assign scl_fall = armed_s & ~scl_now_s & scl_d_r;
    assign sda_s    = sda_now_s;

endmodule

// File: rtl/i2c_codec_target.sv
// i2c_codec_target
// I2C write-only target standing in for a WM8731 codec control port.
// Accepts <addr+W> followed by any number of byte pairs {reg[6:0],data[8]},
// {data[7:0]}; each completed pair commits into a 10-entry register bank.
//   clk, rst          50 MHz clock, synchronous active-high reset
//   scl_in, sda_in    bus pins (asynchronous)
//   sda_oe            1 = pull SDA low (ACK)
//   wr_valid          one-cycle commit strobe; wr_addr/wr_data hold the commit
//   rd_addr/rd_data   combinational bank read, zero beyond register 9
//   busy              transaction in progress (START..STOP)
//   nack_cnt          saturating count of refused address bytes
// Writing register 7'h0F restores every bank register to its default.
module i2c_codec_target
    import codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic [7:0] nack_cnt
);

    logic start_s;
    logic stop_s;
    logic scl_rise_s;
    logic scl_fall_s;
    logic sda_sync_s;

    codec_state_e state_r;
    codec_state_e state_nx_s;
    logic [3:0]   bit_cnt_r;
    logic [3:0]   bit_cnt_nx_s;
    logic [7:0]   shift_r;
    logic [7:0]   shift_nx_s;
    logic [7:0]   byte1_r;
    logic [7:0]   byte1_nx_s;
    logic         sda_oe_r;
    logic         sda_oe_nx_s;
    logic         busy_r;
    logic         busy_nx_s;
    logic         nack_inc_s;
    logic         commit_s;
    logic         shift_en_s;
    logic         byte_done_s;

    logic         wr_valid_r;
    logic [6:0]   wr_addr_r;
    logic [8:0]   wr_data_r;
    logic [7:0]   nack_cnt_r;
    logic [8:0]   bank_r [CODEC_NUM_REGS];
    logic [8:0]   rd_data_s;

    i2c_bus_cond #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_cond (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .start    (start_s),
        .stop     (stop_s),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .sda_s    (sda_sync_s)
    );

    // A bit is taken on each SCL rise until eight are held; the byte is
    // complete on the SCL fall that follows the eighth bit.
    assign shift_en_s  = scl_rise_s && (bit_cnt_r < 4'd8);
    assign byte_done_s = scl_fall_s && (bit_cnt_r == 4'd8);

    // Protocol next-state, shifter and ACK-drive decisions.
    always_comb begin
        state_nx_s   = state_r;
        bit_cnt_nx_s = bit_cnt_r;
        shift_nx_s   = shift_r;
        byte1_nx_s   = byte1_r;
        sda_oe_nx_s  = sda_oe_r;
        busy_nx_s    = busy_r;
        nack_inc_s   = 1'b0;
        commit_s     = 1'b0;

        if (stop_s) begin
            state_nx_s   = ST_IDLE;
            bit_cnt_nx_s = 4'd0;
            sda_oe_nx_s  = 1'b0;
            busy_nx_s    = 1'b0;
        end else if (start_s) begin
            // Repeated START drops any partial byte or uncommitted pair.
            state_nx_s   = ST_ADDR;
            bit_cnt_nx_s = 4'd0;
            sda_oe_nx_s  = 1'b0;
            busy_nx_s    = 1'b1;
        end else begin
            case (state_r)
                ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                    if (shift_en_s) begin
                        shift_nx_s   = {shift_r[6:0], sda_sync_s};
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end else if (byte_done_s) begin
                        bit_cnt_nx_s = 4'd0;
                        if (state_r == ST_ADDR) begin
                            if (shift_r == {DEV_ADDR, 1'b0}) begin
                                state_nx_s  = ST_ADDR_ACK;
                                sda_oe_nx_s = 1'b1;
                            end else begin
                                // Wrong address or a read request: stay off the bus.
                                state_nx_s = ST_IGNORE;
                                nack_inc_s = 1'b1;
                            end
                        end else if (state_r == ST_BYTE1) begin
                            byte1_nx_s  = shift_r;
                            state_nx_s  = ST_ACK1;
                            sda_oe_nx_s = 1'b1;
                        end else begin
                            state_nx_s  = ST_ACK2;
                            sda_oe_nx_s = 1'b1;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
                    // The ACK clock's rising edge is the master's sample point;
                    // only its falling edge releases SDA.
                    if (scl_fall_s) begin
                        sda_oe_nx_s  = 1'b0;
                        bit_cnt_nx_s = 4'd0;
                        if (state_r == ST_ADDR_ACK) begin
                            state_nx_s = ST_BYTE1;
                        end else if (state_r == ST_ACK1) begin
                            state_nx_s = ST_BYTE2;
                        end else begin
                            state_nx_s = ST_BYTE1;
                            commit_s   = 1'b1;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    state_nx_s = state_r;
                end
                default: begin
                    state_nx_s  = ST_IDLE;
                    sda_oe_nx_s = 1'b0;
                    busy_nx_s   = 1'b0;
                end
            endcase
        end
    end

    // FSM state, bit counter, shifter, first-byte hold, SDA drive and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            byte1_r   <= 8'h00;
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            shift_r   <= shift_nx_s;
            byte1_r   <= byte1_nx_s;
            sda_oe_r  <= sda_oe_nx_s;
            busy_r    <= busy_nx_s;
        end
    end

    // Commit strobe and held write report; shift_r still holds the second
    // byte during ACK2 because nothing is shifted in an ACK state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid_r <= 1'b0;
            wr_addr_r  <= 7'h00;
            wr_data_r  <= 9'h000;
        end else if (commit_s) begin
            wr_valid_r <= 1'b1;
            wr_addr_r  <= byte1_r[7:1];
            wr_data_r  <= {byte1_r[0], shift_r};
        end else begin
            wr_valid_r <= 1'b0;
        end
    end

    // Saturating refused-address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            nack_cnt_r <= 8'h00;
        end else if (nack_inc_s && (nack_cnt_r != 8'hFF)) begin
            nack_cnt_r <= nack_cnt_r + 8'h01;
        end else begin
            nack_cnt_r <= nack_cnt_r;
        end
    end

    // Register bank, written from the registered commit report.
    always_ff @(posedge clk) begin
        if (rst || (wr_valid_r && (wr_addr_r == CODEC_RESET_REG))) begin
            for (int i = 0; i < CODEC_NUM_REGS; i++) begin
                bank_r[i] <= codec_default(4'(i));
            end
        end else if (wr_valid_r) begin
            for (int i = 0; i < CODEC_NUM_REGS; i++) begin
                if (wr_addr_r == 7'(i)) begin
                    bank_r[i] <= wr_data_r;
                end
            end
        end
    end

    // Combinational bank read; indices past the bank read as zero.
    always_comb begin
        rd_data_s = 9'h000;
        for (int i = 0; i < CODEC_NUM_REGS; i++) begin
            rd_data_s = (rd_addr == 4'(i)) ? bank_r[i] : rd_data_s;
        end
    end

    assign sda_oe   = sda_oe_r;
    assign wr_valid = wr_valid_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign busy     = busy_r;
    assign nack_cnt = nack_cnt_r;
    assign rd_data  = rd_data_s;

endmodule

// File: tb/tb_i2c_codec_target.sv
// tb_i2c_codec_target
// Bench acting as bus master. A transaction-level model (expected bank,
// expected commit queue, expected NACK count) is updated from the byte
// sequences sent; a monitor process compares commit strobes and, whenever
// the bus is idle, the held outputs against that model every cycle.
module tb_i2c_codec_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl;
    logic       m_sda;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;
    logic [7:0] nack_cnt;

    int          checks    = 0;
    int          failures  = 0;
    int          q         = 8;
    bit          quiet     = 1'b0;
    int          oe_cycles = 0;
    int          wv_count  = 0;
    logic        wv_prev   = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] e_w;
    int          exp_nack  = 0;
    logic [6:0]  exp_wr_addr = 7'h00;
    logic [8:0]  exp_wr_data = 9'h000;
    logic [8:0]  model_bank [10];
    logic [8:0]  dflt [10];

    // Open-drain bus: the line is low if either side pulls it.
    assign scl_in = m_scl;
    assign sda_in = m_sda & ~sda_oe;

    always #10 clk = ~clk;

    i2c_codec_target #(
        .DEV_ADDR    (7'h1A),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .nack_cnt (nack_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic addr_acked(input logic [7:0] b);
        return (b[7:1] == 7'h1A) && (b[0] == 1'b0);
    endfunction

    task automatic model_commit(input logic [7:0] b1, input logic [7:0] b2);
        logic [6:0] r;
        logic [8:0] d;
        r = b1[7:1];
        d = {b1[0], b2};
        exp_q.push_back({r, d});
        exp_wr_addr = r;
        exp_wr_data = d;
        if (r < 7'd10) model_bank[r[3:0]] = d;
        else if (r == 7'h0F) model_bank = dflt;
    endtask

    task automatic bus_start();
        quiet = 1'b0;
        m_sda = 1'b1; wait_q(q);
        m_scl = 1'b1; wait_q(q);
        m_sda = 1'b0; wait_q(q);
        m_scl = 1'b0; wait_q(q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q(q);
        m_scl = 1'b1; wait_q(q);
        m_sda = 1'b1; wait_q(q);
    endtask

    task automatic settle();
        wait_q(12);
        quiet = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_q(q);
        m_scl = 1'b1; wait_q(2 * q);
        m_scl = 1'b0; wait_q(q);
    endtask

    // ack = 1 when the target held SDA low during the ninth clock.
    task automatic send_ack_clock(output logic ack);
        m_sda = 1'b1; wait_q(q);
        m_scl = 1'b1; wait_q(q);
        ack = (sda_in == 1'b0);
        wait_q(q);
        m_scl = 1'b0; wait_q(q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_ack_clock(ack);
    endtask

    task automatic addr_phase(input logic [7:0] b);
        logic ack;
        bus_start();
        send_byte(b, ack);
        chk("addr_ack", 32'(ack), 32'(addr_acked(b)));
        if (!addr_acked(b) && exp_nack < 255) exp_nack++;
    endtask

    // Data bytes are always ACKed; the pair commits at the end of the second.
    task automatic write_pair(input logic [7:0] b1, input logic [7:0] b2);
        logic ack;
        send_byte(b1, ack);
        chk("byte1_ack", 32'(ack), 32'd1);
        model_commit(b1, b2);
        send_byte(b2, ack);
        chk("byte2_ack", 32'(ack), 32'd1);
    endtask

    task automatic scan_bank();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            wait_q(1);
            chk($sformatf("bank[%0d]", a), 32'(rd_data), (a < 10) ? 32'(model_bank[a]) : 32'd0);
        end
    endtask

    // Commit monitor plus idle-bus output comparison against the model.
    always @(negedge clk) begin
        if (sda_oe) oe_cycles++;
        if (wr_valid) begin
            wv_count++;
            chk("wr_valid_width", 32'(wv_prev), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_valid_unexpected: got pulse addr=%0h data=%0h expected none", wr_addr, wr_data);
            end else begin
                e_w = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e_w[15:9]));
                chk("wr_data", 32'(wr_data), 32'(e_w[8:0]));
            end
        end
        wv_prev = wr_valid;
        if (quiet) begin
            chk("idle_nack_cnt", 32'(nack_cnt), 32'(exp_nack));
            chk("idle_wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
            chk("idle_wr_data", 32'(wr_data), 32'(exp_wr_data));
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_sda_oe", 32'(sda_oe), 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        int         oe0;
        int         wv0;
        logic [7:0] pb;

        dflt = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        model_bank = dflt;
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; rd_addr = 4'd0;
        wait_q(6);
        rst = 1'b0;
        wait_q(4);

        // Reset state
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_nack_cnt", 32'(nack_cnt), 32'd0);
        rd_addr = 4'd6; wait_q(1);
        chk("rst_r6_literal", 32'(rd_data), 32'h09F);
        scan_bank();
        quiet = 1'b1;

        // 34/0C/00 at 100 kHz: R6 <- 0
        q = 125;
        wv0 = wv_count;
        addr_phase(8'h34);
        write_pair(8'h0C, 8'h00);
        bus_stop();
        settle();
        q = 8;
        chk("s1_wr_addr", 32'(wr_addr), 32'd6);
        chk("s1_wr_data", 32'(wr_data), 32'h000);
        chk("s1_pulses", 32'(wv_count - wv0), 32'd1);
        rd_addr = 4'd6; wait_q(1);
        chk("s1_r6", 32'(rd_data), 32'h000);
        scan_bank();

        // Foreign address 0x36: no ACK, counted, bank untouched
        oe0 = oe_cycles;
        addr_phase(8'h36);
        chk("s2_busy_mid", 32'(busy), 32'd1);
        bus_stop();
        settle();
        chk("s2_no_oe", 32'(oe_cycles - oe0), 32'd0);
        chk("s2_nack_cnt", 32'(nack_cnt), 32'd1);
        scan_bank();

        // Read request 0x35: refused, following byte ignored, IDLE after STOP
        oe0 = oe_cycles;
        addr_phase(8'h35);
        send_byte(8'h55, ack);
        chk("s3_data_ignored", 32'(ack), 32'd0);
        bus_stop();
        settle();
        chk("s3_no_oe", 32'(oe_cycles - oe0), 32'd0);
        chk("s3_nack_cnt", 32'(nack_cnt), 32'd2);
        chk("s3_busy", 32'(busy), 32'd0);

        // 34/08 then the data byte cut short by a repeated START, then 34/09/AB
        wv0 = wv_count;
        addr_phase(8'h34);
        send_byte(8'h08, ack);
        chk("s4_byte1_ack", 32'(ack), 32'd1);
        pb = 8'h12;
        for (int i = 7; i >= 3; i--) send_bit(pb[i]);
        addr_phase(8'h34);
        write_pair(8'h09, 8'hAB);
        bus_stop();
        settle();
        chk("s4_pulses", 32'(wv_count - wv0), 32'd1);
        rd_addr = 4'd4; wait_q(1);
        chk("s4_r4", 32'(rd_data), 32'h1AB);
        scan_bank();

        // 34/05/FF then 34/1E/00: R2 <- 1FF, then whole bank back to defaults
        wv0 = wv_count;
        addr_phase(8'h34);
        write_pair(8'h05, 8'hFF);
        bus_stop();
        settle();
        rd_addr = 4'd2; wait_q(1);
        chk("s5_r2", 32'(rd_data), 32'h1FF);
        addr_phase(8'h34);
        write_pair(8'h1E, 8'h00);
        bus_stop();
        settle();
        chk("s5_pulses", 32'(wv_count - wv0), 32'd2);
        chk("s5_wr_addr", 32'(wr_addr), 32'h0F);
        rd_addr = 4'd2; wait_q(1);
        chk("s5_r2_restored", 32'(rd_data), 32'h079);
        scan_bank();

        // STOP after BYTE1: nothing commits
        wv0 = wv_count;
        addr_phase(8'h34);
        send_byte(8'h09, ack);
        chk("s6_byte1_ack", 32'(ack), 32'd1);
        bus_stop();
        settle();
        chk("s6_pulses", 32'(wv_count - wv0), 32'd0);
        rd_addr = 4'd4; wait_q(1);
        chk("s6_r4", 32'(rd_data), 32'h00A);
        scan_bank();

        // One committed pair, then rst pulsed in the middle of the next BYTE2
        addr_phase(8'h34);
        write_pair(8'h05, 8'hFF);
        send_byte(8'h09, ack);
        chk("s7_byte1_ack", 32'(ack), 32'd1);
        wv0 = wv_count;
        pb = 8'hAB;
        for (int i = 7; i >= 4; i--) send_bit(pb[i]);
        rst = 1'b1;
        wait_q(1);
        rst = 1'b0;
        exp_nack = 0;
        exp_wr_addr = 7'h00;
        exp_wr_data = 9'h000;
        model_bank = dflt;
        oe0 = oe_cycles;
        for (int i = 3; i >= 0; i--) send_bit(pb[i]);
        send_ack_clock(ack);
        chk("s7_no_ack_after_rst", 32'(ack), 32'd0);
        bus_stop();
        settle();
        chk("s7_pulses", 32'(wv_count - wv0), 32'd0);
        chk("s7_no_oe", 32'(oe_cycles - oe0), 32'd0);
        chk("s7_nack_cnt", 32'(nack_cnt), 32'd0);
        rd_addr = 4'd2; wait_q(1);
        chk("s7_r2_default", 32'(rd_data), 32'h079);
        rd_addr = 4'd4; wait_q(1);
        chk("s7_r4_default", 32'(rd_data), 32'h00A);
        scan_bank();
        chk("commits_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
